mic_frame_fifo: RTL
===================

# mic_frame_fifo

Downstream stage of the I2S microphone driver. It captures one six-channel sample frame per `in_vld` pulse and serializes it into a tagged word stream. The stream is buffered in a FIFO and presented on a valid/ready interface to the beamforming/transport logic. Frames are admitted atomically: a frame is either stored whole or dropped and counted, never split.

## Interface
- `DATA_W`, 24: sample width; must match the driver output width.
- `DEPTH`, 64: FIFO depth in words; power of 2, ≥ 8.

- `clk` input 1: block clock; the same clock as the driver's `mic_sck`.
- `rst` input 1: reset; one clock; reset is asynchronous and active-high.
- `in_vld` input 1: one-cycle frame strobe from the driver.
- `in_data0`..`in_data5` input DATA_W each: channel 0..5 samples, stable while `in_vld`=1.
- `m_data` output DATA_W: stream word.
- `m_ch` output 3: channel tag 0..5 (7 = header, only with the macro defined).
- `m_sof` output 1: first word of a frame.
- `m_eof` output 1: last word of a frame (channel 5).
- `m_valid` output 1: word available.
- `m_ready` input 1: consumer accepts the word.
- `drop_cnt` output 16: dropped frames, saturating at 16'hFFFF.
- `fifo_level` output $clog2(DEPTH)+1: words currently stored.

## Operation
- Frame length is F = 6 words. It is 7 when `MIC_FRAME_SEQ_EN` is defined.
- Word format: {`m_eof`, `m_sof`, `m_ch`, `m_data`} is stored per FIFO entry (DATA_W+5 bits).
- FSM has two states:
  - IDLE: on `in_vld`=1 with free space (DEPTH − `fifo_level`) ≥ F, load six holding registers, clear the index to 0, and go to PUSH.
  - IDLE: on `in_vld`=1 without enough free space, stay in IDLE and increment `drop_cnt`.
  - PUSH: write one word per cycle for index 0..F−1. After the last write, return to IDLE.
- `in_vld` while in PUSH: the frame is dropped and `drop_cnt` is incremented. The holding registers are not disturbed.
- Space is reserved at admission, so PUSH never stalls. A write never meets a full FIFO.
- Tagging: `m_sof`=1 on the first word, `m_eof`=1 on the channel-5 word. `m_ch` equals the channel number.
- FIFO is first-word-fall-through. A pop occurs when `m_valid` & `m_ready` are both 1. A simultaneous push and pop leaves `fifo_level` unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `fifo_level`.
- `drop_cnt` saturates: once it reaches 16'hFFFF, further drops are ignored.

## Timing
- Reset values:
  - `m_valid`, `m_sof`, `m_eof` = 0.
  - `m_data` = 0, `m_ch` = 0.
  - `drop_cnt` = 0, `fifo_level` = 0.
  - FSM in IDLE, pointers 0, holding registers 0.
- `in_vld` is sampled at edge N. Holding registers load at N. Words are written at edges N+1..N+F.
- `m_valid` rises after edge N+2 when the FIFO was empty, i.e. one cycle after the first write. Its word is ch0, or the header when the macro is defined.
- With `m_ready` held at 1, one word is output per cycle. The frame ends after edge N+F+1.
- `fifo_level` updates at the write/pop edge. Free-space evaluation at admission uses the level registered before edge N.
- `m_data`, `m_ch`, `m_sof` and `m_eof` hold steady while `m_valid`=1 and `m_ready`=0.
- Reset asserted mid-PUSH or mid-read empties the FIFO immediately and abandons the partial frame. No partial frame reappears after reset is released.
- The frame period from the driver is 64 cycles, which is ≥ F+1, so in normal operation no frame arrives while PUSH is active.

## Configuration
- `MIC_FRAME_SEQ_EN` defined:
  - A 16-bit frame sequence counter is added. It resets to 0 and increments on every admitted frame, wrapping at 16'hFFFF→0.
  - Each frame is prefixed with a header word: `m_ch`=7, `m_sof`=1, `m_data`={8'hA5, seq[15:0]} (lower 16 bits when DATA_W>24, zero-extended).
  - F=7. `m_sof` is 0 on the ch0 word.
  - Dropped frames do not increment the sequence counter.
- `MIC_FRAME_SEQ_EN` undefined: no header and no counter logic. F=6 and ch0 carries `m_sof`.

## Test plan
- Reset, then one `in_vld` with data0..5 = 24'h000001..24'h000006 and `m_ready`=1: six words are output on consecutive cycles with `m_ch` 0..5, `m_sof` on word 0, `m_eof` on word 5, and `m_valid` first high two cycles after `in_vld`.
- `m_ready`=0 with DEPTH=64 and frames every 64 cycles: frames 1..10 are admitted (60 words). Frame 11 is dropped because free space is 4 < 6, so `drop_cnt`=1 and `fifo_level`=60. Draining afterwards yields frames in order with no split frame.
- `in_vld` pulsed at N and N+3: the second frame is dropped (FSM busy), `drop_cnt` increments by 1, and the first frame is output intact.
- Random `m_ready` toggling over 100 frames: the output words match the scoreboard exactly and the data holds stable while stalled.
- Assert `rst` at edge N+3 of a PUSH: all outputs return to reset values asynchronously. After release, `m_valid`=0 until the next `in_vld`, and the next frame is output complete.
- With `MIC_FRAME_SEQ_EN`: three frames, the second dropped by a full FIFO. The headers read 24'hA50000 and 24'hA50001, and each header carries `m_ch`=7 and `m_sof`=1.

Source files
------------

// File: rtl/mic_frame_fifo.sv
// mic_frame_fifo: captures one six-channel frame per in_vld strobe, serializes
// it into tagged words {eof, sof, ch, data} and buffers them in a FWFT FIFO
// with a valid/ready output. Frames are admitted whole or dropped and counted.
// Optional feature macro: MIC_FRAME_SEQ_EN adds a 16-bit frame sequence
// counter and a header word (ch=7, data={8'hA5, seq}) in front of each frame.
module mic_frame_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [DATA_W-1:0]        in_data0,
  input  logic [DATA_W-1:0]        in_data1,
  input  logic [DATA_W-1:0]        in_data2,
  input  logic [DATA_W-1:0]        in_data3,
  input  logic [DATA_W-1:0]        in_data4,
  input  logic [DATA_W-1:0]        in_data5,
  output logic [DATA_W-1:0]        m_data,
  output logic [2:0]               m_ch,
  output logic                     m_sof,
  output logic                     m_eof,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DATA_W + 5;
`ifdef MIC_FRAME_SEQ_EN
  localparam int F = 7;
`else
  localparam int F = 6;
`endif

  typedef enum logic {S_IDLE, S_PUSH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   hold_q [6];
  logic [DATA_W-1:0]   hold_d [6];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                wr_last_q, wr_last_d;
  logic [15:0]         drop_q, drop_d;
`ifdef MIC_FRAME_SEQ_EN
  logic [15:0]         seq_q, seq_d;
  logic [15:0]         seq_hold_q, seq_hold_d;
`endif

  logic [WW-1:0]       mem [DEPTH];
  logic [WW-1:0]       wr_word;
  logic [WW-1:0]       rd_word;
  logic [2:0]          wr_ch;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                pop;
  logic                drop;
  logic [LW-1:0]       free_space;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef MIC_FRAME_SEQ_EN
  function automatic logic [DATA_W-1:0] hdr_data(input logic [15:0] seq);
    return DATA_W'({8'hA5, seq});
  endfunction
`endif

  // Admission, push sequencing, drop counting and FIFO pointer/level bookkeeping
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    drop       = 1'b0;
`ifdef MIC_FRAME_SEQ_EN
    seq_d      = seq_q;
    seq_hold_d = seq_hold_q;
`endif
    // Space is judged against the level registered before this edge.
    free_space = LW'(DEPTH) - level_q;

    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          if (free_space >= LW'(F)) begin
            state_d   = S_PUSH;
            idx_d     = '0;
            hold_d[0] = in_data0;
            hold_d[1] = in_data1;
            hold_d[2] = in_data2;
            hold_d[3] = in_data3;
            hold_d[4] = in_data4;
            hold_d[5] = in_data5;
`ifdef MIC_FRAME_SEQ_EN
            seq_hold_d = seq_q;
            seq_d      = seq_q + 16'd1;
`endif
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_PUSH: begin
        // Space was reserved at admission, so every push cycle writes.
        wr_en = 1'b1;
        if (in_vld) drop = 1'b1;
        if (idx_q == 3'(F - 1)) state_d = S_IDLE;
        else                    idx_d   = idx_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (drop) drop_d = sat_inc16(drop_q);

    pop       = m_valid & m_ready;
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(wr_en) - LW'(pop);
    wr_last_d = wr_en;
  end

  // Build the tagged word for the current push index
  always_comb begin
`ifdef MIC_FRAME_SEQ_EN
    wr_ch = (idx_q == 3'd0) ? 3'd7 : idx_q - 3'd1;
`else
    wr_ch = idx_q;
`endif
    case (wr_ch)
      3'd0:    wr_data = hold_q[0];
      3'd1:    wr_data = hold_q[1];
      3'd2:    wr_data = hold_q[2];
      3'd3:    wr_data = hold_q[3];
      3'd4:    wr_data = hold_q[4];
      3'd5:    wr_data = hold_q[5];
`ifdef MIC_FRAME_SEQ_EN
      3'd7:    wr_data = hdr_data(seq_hold_q);
`endif
      default: wr_data = '0;
    endcase
    wr_word = {wr_ch == 3'd5, idx_q == 3'd0, wr_ch, wr_data};
  end

  // Output view: a word becomes visible one cycle after it was written
  always_comb begin
    m_valid = level_q > LW'(wr_last_q);
    rd_word = mem[rd_ptr_q];
    {m_eof, m_sof, m_ch, m_data} = m_valid ? rd_word : '0;
  end

  assign drop_cnt   = drop_q;
  assign fifo_level = level_q;

  // Word storage; contents are only observed through m_valid, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  // State, holding registers, pointers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      for (int i = 0; i < 6; i++) hold_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      wr_last_q <= 1'b0;
      drop_q    <= '0;
`ifdef MIC_FRAME_SEQ_EN
      seq_q      <= '0;
      seq_hold_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      wr_last_q <= wr_last_d;
      drop_q    <= drop_d;
`ifdef MIC_FRAME_SEQ_EN
      seq_q      <= seq_d;
      seq_hold_q <= seq_hold_d;
`endif
    end
  end

endmodule
